// File: rtl/sort_pkt_checker.sv
// sort_pkt_checker: Avalon-ST sink that checks each packet from the sorter
// for non-decreasing unsigned order, SOP/EOP framing and length, then
// reports per-packet status one cycle after the reporting beat and keeps
// running packet/error/drop counters.
//
// Handshake: a beat is accepted on a rising clk_i edge when snk_valid_i and
// snk_ready_o are both high. snk_ready_o is ready_en_i delayed by one cycle
// and is forced low during reset. Data, SOP and EOP are ignored on any edge
// where no beat is accepted, and the source must hold them until accepted.
module sort_pkt_checker #(
    parameter  int DWIDTH      = 32,
    parameter  int MAX_PKT_LEN = 256,
    localparam int LWIDTH      = $clog2(MAX_PKT_LEN + 2)
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    input  logic              ready_en_i,
    output logic              pkt_done_o,
    output logic [LWIDTH-1:0] pkt_len_o,
    output logic              pkt_order_err_o,
    output logic              pkt_frame_err_o,
    output logic              pkt_len_err_o,
    output logic [31:0]       pkt_cnt_o,
    output logic [31:0]       err_cnt_o,
    output logic [31:0]       drop_cnt_o
);

    // Length constants: 1 word, legal maximum, and the saturation value.
    localparam logic [LWIDTH-1:0] LEN_ONE = LWIDTH'(1);
    localparam logic [LWIDTH-1:0] LEN_MAX = LWIDTH'(MAX_PKT_LEN);
    localparam logic [LWIDTH-1:0] LEN_SAT = LWIDTH'(MAX_PKT_LEN + 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_e;

    // One packet status report as it travels to the output registers.
    typedef struct packed {
        logic              vld;
        logic [LWIDTH-1:0] len;
        logic              ord;
        logic              frame;
        logic              lerr;
    } rep_t;

    // Packet tracking state.
    state_e            state_q, state_d;
    logic [LWIDTH-1:0] len_q, len_d;
    logic [DWIDTH-1:0] prev_q, prev_d;
    logic              ord_err_q, ord_err_d;
    logic              len_err_q, len_err_d;

    // Backpressure and the single-entry pending report slot.
    logic              ready_q;
    rep_t              pend_q, pend_d;

    // Reported status and counters.
    logic              done_q;
    logic [LWIDTH-1:0] rep_len_q;
    logic              rep_ord_q;
    logic              rep_frame_q;
    logic              rep_lerr_q;
    logic [31:0]       pkt_cnt_q;
    logic [31:0]       err_cnt_q;
    logic [31:0]       drop_cnt_q;

    // Combinational helpers.
    logic              beat_acc;
    logic [LWIDTH-1:0] len_inc;
    logic              ord_new;
    logic              lerr_new;
    logic              drop_inc;
    rep_t              rep_a;
    rep_t              rep_b;
    rep_t              emit;
    logic              emit_any_err;

    assign beat_acc = snk_valid_i & ready_q;

    // Next-state logic: packet tracking and up to two reports per beat.
    // rep_a is the first report a beat produces; rep_b only exists when a
    // SOP+EOP beat cuts an open packet short (the cut packet, then itself).
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        prev_d    = prev_q;
        ord_err_d = ord_err_q;
        len_err_d = len_err_q;
        len_inc   = (len_q == LEN_SAT) ? len_q : len_q + LEN_ONE;
        ord_new   = ord_err_q | (snk_data_i < prev_q);
        lerr_new  = len_err_q | (len_inc > LEN_MAX);
        drop_inc  = 1'b0;
        rep_a     = '0;
        rep_b     = '0;

        if (beat_acc) begin
            case (state_q)
                ST_IDLE: begin
                    if (snk_startofpacket_i) begin
                        len_d     = LEN_ONE;
                        prev_d    = snk_data_i;
                        ord_err_d = 1'b0;
                        len_err_d = 1'b0;
                        if (snk_endofpacket_i) begin
                            rep_a   = '{vld: 1'b1, len: LEN_ONE, ord: 1'b0,
                                        frame: 1'b0, lerr: 1'b0};
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_IN_PKT;
                        end
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
                ST_IN_PKT: begin
                    if (snk_startofpacket_i) begin
                        // Close the open packet with the words seen so far.
                        rep_a     = '{vld: 1'b1, len: len_q, ord: ord_err_q,
                                      frame: 1'b1, lerr: len_err_q};
                        len_d     = LEN_ONE;
                        prev_d    = snk_data_i;
                        ord_err_d = 1'b0;
                        len_err_d = 1'b0;
                        if (snk_endofpacket_i) begin
                            rep_b   = '{vld: 1'b1, len: LEN_ONE, ord: 1'b0,
                                        frame: 1'b0, lerr: 1'b0};
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_IN_PKT;
                        end
                    end else begin
                        len_d     = len_inc;
                        prev_d    = snk_data_i;
                        ord_err_d = ord_new;
                        len_err_d = lerr_new;
                        if (snk_endofpacket_i) begin
                            rep_a   = '{vld: 1'b1, len: len_inc, ord: ord_new,
                                        frame: 1'b0, lerr: lerr_new};
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Report ordering: an older pending report always goes out first and
    // the next report in line waits one cycle in the pending slot. A double
    // report leaves the FSM in IDLE, so at most one report is ever waiting.
    always_comb begin
        emit   = '0;
        pend_d = '0;
        if (pend_q.vld) begin
            emit   = pend_q;
            pend_d = rep_a;
        end else if (rep_a.vld) begin
            emit   = rep_a;
            pend_d = rep_b;
        end
        emit_any_err = emit.ord | emit.frame | emit.lerr;
    end

    // State, report and counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            prev_q      <= '0;
            ord_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
            ready_q     <= 1'b0;
            pend_q      <= '0;
            done_q      <= 1'b0;
            rep_len_q   <= '0;
            rep_ord_q   <= 1'b0;
            rep_frame_q <= 1'b0;
            rep_lerr_q  <= 1'b0;
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            prev_q    <= prev_d;
            ord_err_q <= ord_err_d;
            len_err_q <= len_err_d;
            ready_q   <= ready_en_i;
            pend_q    <= pend_d;
            done_q    <= emit.vld;
            if (emit.vld) begin
                rep_len_q   <= emit.len;
                rep_ord_q   <= emit.ord;
                rep_frame_q <= emit.frame;
                rep_lerr_q  <= emit.lerr;
                pkt_cnt_q   <= pkt_cnt_q + 32'd1;
                if (emit_any_err) begin
                    err_cnt_q <= err_cnt_q + 32'd1;
                end
            end
            if (drop_inc) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
        end
    end

    assign snk_ready_o     = ready_q;
    assign pkt_done_o      = done_q;
    assign pkt_len_o       = rep_len_q;
    assign pkt_order_err_o = rep_ord_q;
    assign pkt_frame_err_o = rep_frame_q;
    assign pkt_len_err_o   = rep_lerr_q;
    assign pkt_cnt_o       = pkt_cnt_q;
    assign err_cnt_o       = err_cnt_q;
    assign drop_cnt_o      = drop_cnt_q;

endmodule

// File: tb/tb_sort_pkt_checker.sv
// Bench for sort_pkt_checker: directed packets from the test plan, then a
// randomized phase, all compared every cycle against a packet-level model.
module tb_sort_pkt_checker;

    localparam int DW   = 8;
    localparam int MAXL = 4;
    localparam int LW   = $clog2(MAXL + 2);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          srst     = 1'b1;
    logic [DW-1:0] snk_data = '0;
    logic          snk_sop  = 1'b0;
    logic          snk_eop  = 1'b0;
    logic          snk_valid = 1'b0;
    logic          snk_ready;
    logic          ready_en = 1'b1;
    logic          pkt_done;
    logic [LW-1:0] pkt_len;
    logic          pkt_ord, pkt_frame, pkt_lerr;
    logic [31:0]   pkt_cnt, err_cnt, drop_cnt;

    sort_pkt_checker #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL)) dut (
        .clk_i(clk), .srst_i(srst),
        .snk_data_i(snk_data), .snk_startofpacket_i(snk_sop),
        .snk_endofpacket_i(snk_eop), .snk_valid_i(snk_valid),
        .snk_ready_o(snk_ready), .ready_en_i(ready_en),
        .pkt_done_o(pkt_done), .pkt_len_o(pkt_len),
        .pkt_order_err_o(pkt_ord), .pkt_frame_err_o(pkt_frame),
        .pkt_len_err_o(pkt_lerr), .pkt_cnt_o(pkt_cnt),
        .err_cnt_o(err_cnt), .drop_cnt_o(drop_cnt)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;
    int rdy_mode = 0;   // 0 hold, 1 toggle, 2 random

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [LW-1:0] len;
        logic          ord;
        logic          frame;
        logic          lerr;
    } rep_t;

    logic [DW-1:0] cur_q[$];     // words of the open packet
    rep_t          rep_q[$];     // reports waiting to be shown
    rep_t          rep_log[$];   // every report shown, for literal checks
    bit            in_pkt = 1'b0;
    bit            m_acc  = 1'b0;
    logic          e_ready = 1'b0;
    logic          e_done  = 1'b0;
    rep_t          e_rep   = '0;
    logic [31:0]   e_pkt = '0, e_err = '0, e_drop = '0;

    function automatic rep_t make_rep(input bit frame);
        rep_t r;
        int   n;
        n       = cur_q.size();
        r.len   = (n > MAXL) ? LW'(MAXL + 1) : LW'(n);
        r.lerr  = (n > MAXL);
        r.frame = frame;
        r.ord   = 1'b0;
        for (int i = 1; i < n; i++)
            if (cur_q[i] < cur_q[i-1]) r.ord = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        if (srst) begin
            cur_q.delete(); rep_q.delete();
            in_pkt = 1'b0; m_acc = 1'b0; e_ready = 1'b0; e_done = 1'b0;
            e_rep = '0; e_pkt = '0; e_err = '0; e_drop = '0;
        end else begin
            m_acc = snk_valid && e_ready;
            if (m_acc) begin
                if (snk_sop) begin
                    if (in_pkt) rep_q.push_back(make_rep(1'b1));
                    cur_q.delete();
                    cur_q.push_back(snk_data);
                    in_pkt = 1'b1;
                end else if (in_pkt) begin
                    cur_q.push_back(snk_data);
                end else begin
                    e_drop++;
                end
                if (in_pkt && snk_eop) begin
                    rep_q.push_back(make_rep(1'b0));
                    in_pkt = 1'b0;
                end
            end
            if (rep_q.size() > 0) begin
                e_rep  = rep_q.pop_front();
                e_done = 1'b1;
                e_pkt++;
                if (e_rep.ord || e_rep.frame || e_rep.lerr) e_err++;
                rep_log.push_back(e_rep);
            end else begin
                e_done = 1'b0;
            end
            e_ready = ready_en;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("snk_ready", snk_ready, e_ready);
            chk("pkt_done", pkt_done, e_done);
            chk("pkt_len", pkt_len, e_rep.len);
            chk("pkt_order_err", pkt_ord, e_rep.ord);
            chk("pkt_frame_err", pkt_frame, e_rep.frame);
            chk("pkt_len_err", pkt_lerr, e_rep.lerr);
            chk("pkt_cnt", pkt_cnt, e_pkt);
            chk("err_cnt", err_cnt, e_err);
            chk("drop_cnt", drop_cnt, e_drop);
        end
    end

    // ready_en drive modes
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) ready_en = ~ready_en;
        else if (rdy_mode == 2) ready_en = ($urandom_range(0, 3) != 0);
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int n);
        srst = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
            cmp_on = 1'b1;
            @(negedge clk);
            chk("rst_ready", snk_ready, 1'b0);
            chk("rst_done", pkt_done, 1'b0);
        end
        srst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input bit s, input bit e);
        int n;
        snk_valid = 1'b1; snk_data = d; snk_sop = s; snk_eop = e;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!m_acc && n < 100);
        if (!m_acc) chk("beat_timeout", 32'd0, 32'd1);
        snk_valid = 1'b0;
        snk_data  = DW'($urandom);
        snk_sop   = 1'($urandom);
        snk_eop   = 1'($urandom);
    endtask

    task automatic send_pkt(input logic [DW-1:0] w[$]);
        for (int i = 0; i < w.size(); i++)
            send_beat(w[i], i == 0, i == w.size() - 1);
    endtask

    // ---------------- stimulus ----------------
    int ls;
    initial begin
        do_reset(3);
        idle(2);

        // {1,2,2,7}: clean packet
        send_pkt('{8'd1, 8'd2, 8'd2, 8'd7});
        idle(3);
        chk("t1_reports", rep_log.size(), 1);
        chk("t1_len", rep_log[0].len, 4);
        chk("t1_flags", {rep_log[0].ord, rep_log[0].frame, rep_log[0].lerr}, 0);
        chk("t1_pkt_cnt", e_pkt, 1);
        chk("t1_err_cnt", e_err, 0);

        // {5,3,9}: order error, then {4}: clean single word
        send_pkt('{8'd5, 8'd3, 8'd9});
        idle(3);
        ls = rep_log.size();
        chk("t2_len", rep_log[ls-1].len, 3);
        chk("t2_ord", rep_log[ls-1].ord, 1);
        chk("t2_err_cnt", e_err, 1);
        send_pkt('{8'd4});
        idle(3);
        ls = rep_log.size();
        chk("t2b_len", rep_log[ls-1].len, 1);
        chk("t2b_flags", {rep_log[ls-1].ord, rep_log[ls-1].frame, rep_log[ls-1].lerr}, 0);

        // frame cut: SOP 10, 20, SOP 1, 2 EOP
        send_beat(8'd10, 1, 0); send_beat(8'd20, 0, 0);
        send_beat(8'd1, 1, 0);  send_beat(8'd2, 0, 1);
        idle(3);
        ls = rep_log.size();
        chk("t3a_len", rep_log[ls-2].len, 2);
        chk("t3a_frame", rep_log[ls-2].frame, 1);
        chk("t3b_len", rep_log[ls-1].len, 2);
        chk("t3b_frame", rep_log[ls-1].frame, 0);

        // 6 ascending words with MAX_PKT_LEN=4: saturated length
        send_pkt('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6});
        idle(3);
        ls = rep_log.size();
        chk("t4_len", rep_log[ls-1].len, 5);
        chk("t4_lerr", rep_log[ls-1].lerr, 1);
        chk("t4_ord", rep_log[ls-1].ord, 0);

        // SOP+EOP cutting an open packet: two back-to-back reports
        send_beat(8'd9, 1, 0); send_beat(8'd8, 0, 0); send_beat(8'd3, 1, 1);
        send_pkt('{8'd6});
        idle(4);
        ls = rep_log.size();
        chk("t4b_cut_len", rep_log[ls-3].len, 2);
        chk("t4b_cut_frame", rep_log[ls-3].frame, 1);
        chk("t4b_single_len", rep_log[ls-2].len, 1);
        chk("t4b_last_len", rep_log[ls-1].len, 1);

        // drops in IDLE
        do_reset(2);
        send_beat(8'd7, 0, 0); send_beat(8'd8, 0, 1);
        send_pkt('{8'd0});
        idle(3);
        chk("t5_drop", e_drop, 2);
        chk("t5_pkt", e_pkt, 1);
        chk("t5_dut_drop", drop_cnt, 2);

        // toggled backpressure, then reset mid-packet
        rdy_mode = 1;
        send_pkt('{8'd3, 8'd4, 8'd5, 8'd6});
        rdy_mode = 0; ready_en = 1'b1;
        idle(3);
        ls = rep_log.size();
        chk("t6_len", rep_log[ls-1].len, 4);
        chk("t6_pkt", e_pkt, 2);
        send_beat(8'd1, 1, 0); send_beat(8'd2, 0, 0);
        do_reset(2);
        idle(4);
        chk("t6_no_report", rep_log.size(), ls);
        chk("t6_pkt_cnt", pkt_cnt, 0);
        chk("t6_drop_cnt", drop_cnt, 0);

        // randomized phase
        rdy_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset($urandom_range(1, 2));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
            send_beat(DW'($urandom_range(0, 15)),
                      in_pkt ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 7) != 0),
                      $urandom_range(0, 3) == 0);
        end
        rdy_mode = 0; ready_en = 1'b1;
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
